// File: rtl/sysctl.sv
// System controller on the CSR bridge: LED GPIOs with an edge interrupt,
// two 32-bit match timers, the system ID register and a software reset request.
module sysctl #(
  parameter logic [3:0]  csr_addr = 4'h1,
  parameter int          ninputs  = 4,
  parameter int          noutputs = 4,
  parameter logic [31:0] systemid = 32'h50465231
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [13:0]         csr_a,
  input  logic                csr_we,
  input  logic [31:0]         csr_di,
  output logic [31:0]         csr_do,
  input  logic [ninputs-1:0]  gpio_in,
  output logic [noutputs-1:0] gpio_out,
  output logic                gpio_irq,
  output logic                timer0_irq,
  output logic                timer1_irq,
  output logic                hard_reset
);

  localparam logic [9:0] IDX_GPIO_IN    = 10'h000;
  localparam logic [9:0] IDX_GPIO_OUT   = 10'h001;
  localparam logic [9:0] IDX_GPIO_IRQEN = 10'h002;
  localparam logic [9:0] IDX_T0_CTRL    = 10'h003;
  localparam logic [9:0] IDX_T0_COMPARE = 10'h004;
  localparam logic [9:0] IDX_T0_COUNTER = 10'h005;
  localparam logic [9:0] IDX_T1_CTRL    = 10'h006;
  localparam logic [9:0] IDX_T1_COMPARE = 10'h007;
  localparam logic [9:0] IDX_T1_COUNTER = 10'h008;
  localparam logic [9:0] IDX_ID         = 10'h01E;
  localparam logic [9:0] IDX_RESET      = 10'h01F;

  logic [ninputs-1:0]  sync1_q, sync1_d;
  logic [ninputs-1:0]  sync2_q, sync2_d;
  logic [ninputs-1:0]  hist_q, hist_d;
  logic [ninputs-1:0]  irqen_q, irqen_d;
  logic [noutputs-1:0] gpio_out_q, gpio_out_d;
  logic                gpio_irq_q, gpio_irq_d;
  logic                hard_reset_q, hard_reset_d;
  logic [31:0]         csr_do_q, csr_do_d;

  logic [1:0][1:0]     ctrl_q, ctrl_d;
  logic [1:0][31:0]    compare_q, compare_d;
  logic [1:0][31:0]    counter_q, counter_d;
  logic [1:0]          timer_irq_q, timer_irq_d;

  logic                sel;
  logic                wr_en;
  logic [9:0]          idx;
  logic [31:0]         rdata;
  logic [1:0]          ctrl_wr, compare_wr, counter_wr, t_match;

  assign sel   = (csr_a[13:10] == csr_addr);
  assign idx   = csr_a[9:0];
  assign wr_en = sel && csr_we;

  assign ctrl_wr    = {wr_en && (idx == IDX_T1_CTRL),    wr_en && (idx == IDX_T0_CTRL)};
  assign compare_wr = {wr_en && (idx == IDX_T1_COMPARE), wr_en && (idx == IDX_T0_COMPARE)};
  assign counter_wr = {wr_en && (idx == IDX_T1_COUNTER), wr_en && (idx == IDX_T0_COUNTER)};

  assign t_match[0] = ctrl_q[0][0] && (counter_q[0] == compare_q[0]);
  assign t_match[1] = ctrl_q[1][0] && (counter_q[1] == compare_q[1]);

  // Next-state for GPIO, CSR read mux, software reset and both timers
  always_comb begin
    sync1_d      = gpio_in;
    sync2_d      = sync1_q;
    hist_d       = sync2_q;
    gpio_irq_d   = |((sync2_q ^ hist_q) & irqen_q);
    hard_reset_d = wr_en && (idx == IDX_RESET);

    if (wr_en && (idx == IDX_GPIO_OUT)) begin
      gpio_out_d = csr_di[noutputs-1:0];
    end else begin
      gpio_out_d = gpio_out_q;
    end

    if (wr_en && (idx == IDX_GPIO_IRQEN)) begin
      irqen_d = csr_di[ninputs-1:0];
    end else begin
      irqen_d = irqen_q;
    end

    rdata = 32'd0;
    case (idx)
      IDX_GPIO_IN:    rdata = 32'(sync2_q);
      IDX_GPIO_OUT:   rdata = 32'(gpio_out_q);
      IDX_GPIO_IRQEN: rdata = 32'(irqen_q);
      IDX_T0_CTRL:    rdata = {30'd0, ctrl_q[0]};
      IDX_T0_COMPARE: rdata = compare_q[0];
      IDX_T0_COUNTER: rdata = counter_q[0];
      IDX_T1_CTRL:    rdata = {30'd0, ctrl_q[1]};
      IDX_T1_COMPARE: rdata = compare_q[1];
      IDX_T1_COUNTER: rdata = counter_q[1];
      IDX_ID:         rdata = systemid;
      default:        rdata = 32'd0;
    endcase

    if (sel) begin
      csr_do_d = rdata;
    end else begin
      csr_do_d = 32'd0;
    end

    // A CSR write to CTRL or COUNTER on a match cycle overrides the timer and drops its irq
    for (int t = 0; t < 2; t++) begin
      timer_irq_d[t] = t_match[t] && !ctrl_wr[t] && !counter_wr[t];

      if (counter_wr[t]) begin
        counter_d[t] = csr_di;
      end else if (t_match[t]) begin
        counter_d[t] = 32'd0;
      end else if (ctrl_q[t][0]) begin
        counter_d[t] = counter_q[t] + 32'd1;
      end else begin
        counter_d[t] = counter_q[t];
      end

      if (ctrl_wr[t]) begin
        ctrl_d[t] = csr_di[1:0];
      end else if (t_match[t]) begin
        ctrl_d[t] = {ctrl_q[t][1], ctrl_q[t][1]};
      end else begin
        ctrl_d[t] = ctrl_q[t];
      end

      if (compare_wr[t]) begin
        compare_d[t] = csr_di;
      end else begin
        compare_d[t] = compare_q[t];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      hist_q       <= '0;
      irqen_q      <= '0;
      gpio_out_q   <= '0;
      gpio_irq_q   <= 1'b0;
      hard_reset_q <= 1'b0;
      csr_do_q     <= 32'd0;
      ctrl_q       <= {2{2'b00}};
      compare_q    <= {2{32'hFFFF_FFFF}};
      counter_q    <= {2{32'd0}};
      timer_irq_q  <= 2'b00;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      irqen_q      <= irqen_d;
      gpio_out_q   <= gpio_out_d;
      gpio_irq_q   <= gpio_irq_d;
      hard_reset_q <= hard_reset_d;
      csr_do_q     <= csr_do_d;
      ctrl_q       <= ctrl_d;
      compare_q    <= compare_d;
      counter_q    <= counter_d;
      timer_irq_q  <= timer_irq_d;
    end
  end

  assign csr_do     = csr_do_q;
  assign gpio_out   = gpio_out_q;
  assign gpio_irq   = gpio_irq_q;
  assign timer0_irq = timer_irq_q[0];
  assign timer1_irq = timer_irq_q[1];
  assign hard_reset = hard_reset_q;

endmodule

// File: tb/tb_sysctl.sv
// Bench for sysctl: directed scenarios with literal expectations, then random CSR/GPIO
// traffic, all outputs compared each cycle against a register-map level model.
module tb_sysctl;

  localparam logic [3:0]  CSR_ADDR = 4'h1;
  localparam logic [31:0] SYSID    = 32'h50465231;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic [3:0]  gpio_in;
  logic [3:0]  gpio_out;
  logic        gpio_irq, timer0_irq, timer1_irq, hard_reset;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sysctl #(.csr_addr(CSR_ADDR), .ninputs(4), .noutputs(4), .systemid(SYSID)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di),
    .csr_do(csr_do), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_irq(gpio_irq),
    .timer0_irq(timer0_irq), .timer1_irq(timer1_irq), .hard_reset(hard_reset)
  );

  // Reference model state: register map contents plus expected registered outputs
  logic [3:0]  m_s1, m_s2, m_hist, m_out, m_irqen;
  logic [1:0]  m_ctrl [2];
  logic [31:0] m_cmp [2];
  logic [31:0] m_cnt [2];
  logic        m_tirq [2];
  logic        m_girq, m_hr;
  logic [31:0] m_do;

  always @(posedge clk) begin : model
    logic        sel, wr;
    int          ix, t, r;
    logic [31:0] rd;
    logic [1:0]  nctrl;
    logic [31:0] ncnt;
    logic        nirq;
    if (sys_rst) begin
      m_s1 <= 4'd0; m_s2 <= 4'd0; m_hist <= 4'd0; m_out <= 4'd0; m_irqen <= 4'd0;
      m_girq <= 1'b0; m_hr <= 1'b0; m_do <= 32'd0;
      for (int k = 0; k < 2; k++) begin
        m_ctrl[k] <= 2'd0; m_cmp[k] <= 32'hFFFF_FFFF; m_cnt[k] <= 32'd0; m_tirq[k] <= 1'b0;
      end
    end else begin
      sel = (csr_a[13:10] == CSR_ADDR);
      wr  = sel && csr_we;
      ix  = int'(csr_a[9:0]);
      rd  = 32'd0;
      if (sel && ix == 0) rd = {28'd0, m_s2};
      if (sel && ix == 1) rd = {28'd0, m_out};
      if (sel && ix == 2) rd = {28'd0, m_irqen};
      if (sel && ix >= 3 && ix <= 8) begin
        t = (ix - 3) / 3;
        r = (ix - 3) % 3;
        rd = (r == 0) ? {30'd0, m_ctrl[t]} : (r == 1) ? m_cmp[t] : m_cnt[t];
      end
      if (sel && ix == 30) rd = SYSID;
      m_do   <= rd;
      m_girq <= |((m_s2 ^ m_hist) & m_irqen);
      m_s1   <= gpio_in;
      m_s2   <= m_s1;
      m_hist <= m_s2;
      m_hr   <= wr && ix == 31;
      if (wr && ix == 1) m_out <= csr_di[3:0];
      if (wr && ix == 2) m_irqen <= csr_di[3:0];
      for (int k = 0; k < 2; k++) begin
        nctrl = m_ctrl[k];
        ncnt  = m_cnt[k];
        nirq  = 1'b0;
        if (m_ctrl[k][0]) begin
          if (m_cnt[k] == m_cmp[k]) begin
            nirq = 1'b1;
            ncnt = 32'd0;
            if (!m_ctrl[k][1]) nctrl[0] = 1'b0;
          end else begin
            ncnt = m_cnt[k] + 32'd1;
          end
        end
        if (wr && ix == 3 + 3 * k) begin nctrl = csr_di[1:0]; nirq = 1'b0; end
        if (wr && ix == 5 + 3 * k) begin ncnt = csr_di; nirq = 1'b0; end
        if (wr && ix == 4 + 3 * k) m_cmp[k] <= csr_di;
        m_ctrl[k] <= nctrl;
        m_cnt[k]  <= ncnt;
        m_tirq[k] <= nirq;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("csr_do",     csr_do,                m_do);
      check("gpio_out",   {28'd0, gpio_out},     {28'd0, m_out});
      check("gpio_irq",   {31'd0, gpio_irq},     {31'd0, m_girq});
      check("timer0_irq", {31'd0, timer0_irq},   {31'd0, m_tirq[0]});
      check("timer1_irq", {31'd0, timer1_irq},   {31'd0, m_tirq[1]});
      check("hard_reset", {31'd0, hard_reset},   {31'd0, m_hr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] ix, input logic [31:0] d);
    csr_a = {CSR_ADDR, ix}; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [9:0] ix, output logic [31:0] d);
    csr_a = {CSR_ADDR, ix}; csr_we = 1'b0;
    @(negedge clk);
    d = csr_do;
  endtask

  logic [31:0] d;

  initial begin
    sys_rst = 1'b1; csr_we = 1'b0; csr_a = 14'd0; csr_di = 32'd0; gpio_in = 4'd0;
    tick(2);
    chk_en = 1'b1;
    check("rst_csr_do",   csr_do, 32'd0);
    check("rst_gpio_out", {28'd0, gpio_out}, 32'd0);
    sys_rst = 1'b0;

    rd(10'h1E, d);  check("id_read", d, 32'h50465231);
    csr_a = {4'h0, 10'h1E}; tick(1); check("id_unselected", csr_do, 32'd0);
    rd(10'h3A, d);  check("unmapped_read", d, 32'd0);

    wr(10'h001, 32'hA); check("gpio_out_drive", {28'd0, gpio_out}, 32'hA);
    rd(10'h001, d);     check("gpio_out_readback", d, 32'hA);
    wr(10'h000, 32'hF); rd(10'h000, d); check("gpio_in_ro", d, 32'd0);

    wr(10'h002, 32'h1);
    gpio_in = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick(1); check("gpio_irq_edge", {31'd0, gpio_irq}, (k == 3) ? 32'd1 : 32'd0);
    end
    gpio_in = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      tick(1); check("gpio_irq_masked", {31'd0, gpio_irq}, 32'd0);
    end
    rd(10'h000, d); check("gpio_in_sync", d, 32'h3);

    wr(10'h004, 32'd9); wr(10'h005, 32'd0); wr(10'h003, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick(1); check("t0_oneshot", {31'd0, timer0_irq}, (k == 10) ? 32'd1 : 32'd0);
    end
    rd(10'h003, d); check("t0_ctrl_cleared", d, 32'd0);
    rd(10'h005, d); check("t0_counter_zero", d, 32'd0);
    tick(3);
    rd(10'h005, d); check("t0_counter_holds", d, 32'd0);

    wr(10'h004, 32'd5); wr(10'h005, 32'hFFFF_FFFE); wr(10'h003, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      tick(1); check("t0_wrap", {31'd0, timer0_irq}, (k == 8) ? 32'd1 : 32'd0);
    end

    wr(10'h004, 32'd0); wr(10'h005, 32'd0); wr(10'h003, 32'd3);
    for (int k = 1; k <= 4; k++) begin
      tick(1); check("t0_compare_zero", {31'd0, timer0_irq}, 32'd1);
    end
    wr(10'h003, 32'd0);
    check("t0_ctrl_write_wins", {31'd0, timer0_irq}, 32'd0);

    wr(10'h008, 32'd0); wr(10'h007, 32'd3); wr(10'h006, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      tick(1); check("t1_autorestart", {31'd0, timer1_irq}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    tick(3);
    wr(10'h008, 32'd100);
    check("t1_suppressed", {31'd0, timer1_irq}, 32'd0);
    rd(10'h008, d); check("t1_resume_100", d, 32'd100);
    wr(10'h006, 32'd0);

    wr(10'h01F, 32'd0);
    check("hard_reset_pulse", {31'd0, hard_reset}, 32'd1);
    tick(1);
    check("hard_reset_single", {31'd0, hard_reset}, 32'd0);

    wr(10'h004, 32'd2); wr(10'h003, 32'd3); wr(10'h007, 32'd1); wr(10'h006, 32'd3);
    tick(5);
    sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("rst_no_irq", {30'd0, timer1_irq, timer0_irq}, 32'd0);
    end
    rd(10'h004, d); check("rst_compare", d, 32'hFFFF_FFFF);
    rd(10'h003, d); check("rst_ctrl", d, 32'd0);
    rd(10'h005, d); check("rst_counter", d, 32'd0);
    rd(10'h001, d); check("rst_gpio_out", d, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [9:0] ix;
      sys_rst = ($urandom % 400) == 0;
      if (($urandom % 8) == 0) gpio_in = 4'($urandom);
      r = int'($urandom % 20);
      if (r < 9) ix = 10'(r);
      else if (r == 9) ix = 10'h01E;
      else if (r == 10) ix = ($urandom % 4 == 0) ? 10'h01F : 10'($urandom);
      else ix = 10'(3 + r % 6);
      csr_a  = {(($urandom % 8) == 0) ? 4'($urandom) : CSR_ADDR, ix};
      csr_we = ($urandom % 3) == 0;
      csr_di = (($urandom % 4) == 0) ? 32'hFFFF_FFFC + ($urandom % 4) : $urandom_range(0, 12);
      tick(1);
    end
    sys_rst = 1'b0; csr_we = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
